// File: rtl/sha_256_msg_schedule.sv
// sha_256_msg_schedule
//   Streams the 64 SHA-256 message-schedule words W[0..63] for one 512-bit block.
//   A 16-word sliding window holds W[t..t+15]. Each accepted word shifts the window
//   and appends W[t+16] from a single sigma0/sigma1/adder datapath.
//
// Ports
//   clk       clock
//   rstn      asynchronous active-low reset
//   start     one-cycle pulse: load block_in and begin a schedule (ignored while busy)
//   block_in  512-bit message block, sampled only on an accepted start
//   w_ready   consumer accepts w_out this cycle
//   w_valid   w_out holds a valid schedule word
//   w_out     current schedule word W[w_idx]
//   w_idx     index t of w_out, 0..63
//   w_last    high with w_valid while w_idx == 63
//   busy      high while a schedule is being streamed
//   done      one-cycle pulse after W[63] is transferred
//
// Configuration macro
//   SHA_SCHED_BYTE_SWAP_EN  when defined, word j is built little-endian-by-address from
//                           block_in so that byte address 0 becomes the MSB of W[0].
//                           When undefined, word j = block_in[511-32j -: 32].

module sha_256_msg_schedule #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic         w_ready,
  output logic         w_valid,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         w_last,
  output logic         busy,
  output logic         done
);

  if (WORD_W != 32 || NUM_WORDS != 64) begin : g_bad_param
    $error("sha_256_msg_schedule: WORD_W must be 32 and NUM_WORDS must be 64");
  end

  localparam logic [5:0] LastIdx = 6'd63;

  typedef enum logic {StIdle, StRun} state_e;

  state_e              r_state, w_state_d;
  logic [15:0][31:0]   r_window, w_window_d;
  logic [5:0]          r_idx, w_idx_d;
  logic                r_done, w_done_d;
  logic [31:0]         w_next_word;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] load_word(input logic [511:0] blk, input int unsigned j);
`ifdef SHA_SCHED_BYTE_SWAP_EN
    return {blk[32*j +: 8], blk[32*j+8 +: 8], blk[32*j+16 +: 8], blk[32*j+24 +: 8]};
`else
    return blk[511-32*j -: 32];
`endif
  endfunction

  // W[t+16] = sigma1(W[t+14]) + W[t+9] + sigma0(W[t+1]) + W[t], window[0] holding W[t]
  assign w_next_word = sigma1(r_window[14]) + r_window[9] + sigma0(r_window[1]) + r_window[0];

  always_comb begin
    w_state_d  = r_state;
    w_window_d = r_window;
    w_idx_d    = r_idx;
    w_done_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          for (int j = 0; j < 16; j++) begin
            w_window_d[j] = load_word(block_in, j);
          end
          w_idx_d   = '0;
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (w_ready) begin
          if (r_idx == LastIdx) begin
            // Window contents past W[63] are never emitted, so leave them as they are.
            w_idx_d   = '0;
            w_done_d  = 1'b1;
            w_state_d = StIdle;
          end else begin
            for (int i = 0; i < 15; i++) begin
              w_window_d[i] = r_window[i+1];
            end
            w_window_d[15] = w_next_word;
            w_idx_d        = r_idx + 6'd1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= StIdle;
      r_window <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_window <= w_window_d;
      r_idx    <= w_idx_d;
      r_done   <= w_done_d;
    end
  end

  // All outputs derive from registers only; no path from w_ready to w_valid.
  assign w_valid = (r_state == StRun);
  assign busy    = w_valid;
  assign w_out   = w_valid ? r_window[0] : '0;
  assign w_idx   = r_idx;
  assign w_last  = w_valid && (r_idx == LastIdx);
  assign done    = r_done;

endmodule

// File: tb/tb_sha_256_msg_schedule.sv
// Self-checking bench for sha_256_msg_schedule. Each schedule is compared word by word
// against a full 64-entry schedule computed from the block with the textbook recurrence.
module tb_sha_256_msg_schedule;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [511:0] block_in;
  logic         w_ready;
  logic         w_valid;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         w_last;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_w [64];

  always #5 clk = ~clk;

  sha_256_msg_schedule dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .block_in (block_in),
    .w_ready  (w_ready),
    .w_valid  (w_valid),
    .w_out    (w_out),
    .w_idx    (w_idx),
    .w_last   (w_last),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [511:0] blk;
    int           pct;
    int           k_idx;
    logic [31:0]  k_val;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_word(input logic [511:0] blk, input int j);
    logic [31:0] w;
`ifdef SHA_SCHED_BYTE_SWAP_EN
    for (int b = 0; b < 4; b++) w[31-8*b -: 8] = blk[8*(4*j+b) +: 8];
`else
    w = blk[511-32*j -: 32];
`endif
    return w;
  endfunction

  task automatic build_sched(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) exp_w[t] = ref_word(blk, t);
    for (int t = 16; t < 64; t++) begin
      s0 = ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
      s1 = ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
      exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int j = 0; j < 16; j++) b[32*j +: 32] = $urandom;
    return b;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(w_valid), 0);
    check({tag, "_out"},   w_out, 0);
    check({tag, "_idx"},   32'(w_idx), 0);
    check({tag, "_last"},  32'(w_last), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
  endtask

  // One schedule. inj_idx: pulse start with inj_blk while w_idx==inj_idx (must be ignored).
  // abort_idx: pull rstn low at that index and return. chain: start chain_blk in the done cycle.
  task automatic run_sched(input logic [511:0] blk, input int pct, input int k_idx,
                           input logic [31:0] k_val, input bit pre_started, input int inj_idx,
                           input logic [511:0] inj_blk, input int abort_idx, input bit chain,
                           input logic [511:0] chain_blk);
    int          t   = 0;
    int          cyc = 0;
    bit          held = 0;
    logic [31:0] held_out = '0;
    logic [5:0]  held_idx = '0;
    build_sched(blk);
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1; block_in = blk; w_ready = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    check("valid_after_start", 32'(w_valid), 1);
    while (t < 64 && cyc < 3000) begin
      if (t == abort_idx) begin
        rstn = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        check_all_zero("abort_hold");
        rstn = 1'b1;
        return;
      end
      if (held) begin
        check("stall_out", w_out, held_out);
        check("stall_idx", 32'(w_idx), 32'(held_idx));
      end
      check("valid", 32'(w_valid), 1);
      check("busy", 32'(busy), 1);
      check("w_out", w_out, exp_w[t]);
      check("w_idx", 32'(w_idx), 32'(t));
      check("w_last", 32'(w_last), 32'(t == 63));
      check("done_low", 32'(done), 0);
      if (t == k_idx) check("known_word", w_out, k_val);
      start = (t == inj_idx);
      if (start) block_in = inj_blk;
      w_ready  = ($urandom_range(0, 99) < pct);
      held     = !w_ready;
      held_out = w_out;
      held_idx = w_idx;
      if (w_ready) t++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; w_ready = 1'b0;
    if (t < 64) begin
      n_checks++; n_errors++;
      $display("FAIL timeout: transferred %0d words, required 64", t);
    end
    check("done_pulse", 32'(done), 1);
    check("valid_after_last", 32'(w_valid), 0);
    check("busy_after_last", 32'(busy), 0);
    check("idx_after_last", 32'(w_idx), 0);
    check("last_after_last", 32'(w_last), 0);
    if (chain) begin
      start = 1'b1; block_in = chain_blk;
      return;
    end
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("idle_valid", 32'(w_valid), 0);
  endtask

  initial begin
    vec_t         vecs [5];
    logic [511:0] abc_blk;
    logic [511:0] blk_a, blk_b;

`ifdef SHA_SCHED_BYTE_SWAP_EN
    abc_blk = '0;
    abc_blk[7:0]     = 8'h61;
    abc_blk[15:8]    = 8'h62;
    abc_blk[23:16]   = 8'h63;
    abc_blk[31:24]   = 8'h80;
    abc_blk[511:504] = 8'h18;
`else
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
`endif
    blk_a = rand_block();
    blk_b = rand_block();

    vecs[0].blk = '0;      vecs[0].pct = 100; vecs[0].k_idx = 17; vecs[0].k_val = 32'h0;
    vecs[1].blk = abc_blk; vecs[1].pct = 100; vecs[1].k_idx = 16; vecs[1].k_val = 32'h61626380;
    vecs[2].blk = abc_blk; vecs[2].pct = 50;  vecs[2].k_idx = 17; vecs[2].k_val = 32'h000F0000;
    vecs[3].blk = abc_blk; vecs[3].pct = 100; vecs[3].k_idx = 15; vecs[3].k_val = 32'h00000018;
    vecs[4].blk = blk_a;   vecs[4].pct = 70;  vecs[4].k_idx = 0;
    vecs[4].k_val = ref_word(blk_a, 0);

    rstn = 1'b0; start = 1'b0; block_in = '0; w_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    for (int i = 0; i < 5; i++) begin
      run_sched(vecs[i].blk, vecs[i].pct, vecs[i].k_idx, vecs[i].k_val, 1'b0, -1, '0, -1,
                1'b0, '0);
    end

    // Start mid-schedule is ignored.
    run_sched(abc_blk, 100, 0, 32'h61626380, 1'b0, 20, blk_b, -1, 1'b0, '0);
    // Start on the W[63] edge is ignored; start in the done cycle is accepted.
    run_sched(abc_blk, 100, -1, '0, 1'b0, 63, blk_b, -1, 1'b1, blk_b);
    run_sched(blk_b, 100, 0, ref_word(blk_b, 0), 1'b1, -1, '0, -1, 1'b0, '0);

    // Reset mid-schedule, then a clean schedule.
    run_sched(abc_blk, 100, -1, '0, 1'b0, -1, '0, 30, 1'b0, '0);
    run_sched(abc_blk, 60, 17, 32'h000F0000, 1'b0, -1, '0, -1, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
